// File: rtl/i2c_sensor_poller.sv
// i2c_sensor_poller: autonomous Avalon-MM master that sweeps I2C sensors via the bridge.
// Define I2C_SENSOR_POLLER_TIMESTAMP_EN to add per-sensor sample timestamps.
module i2c_sensor_poller #(
  parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
  parameter int unsigned POLL_RATE_HZ   = 100,
  parameter int unsigned NUM_SENSORS    = 4,
  parameter logic [6:0]  BASE_ADDR      = 7'h35,
  parameter int unsigned READ_BYTES     = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);

  localparam int unsigned TICK_PERIOD = CLOCK_SPEED_HZ / POLL_RATE_HZ;
  localparam int unsigned WORDS = (READ_BYTES + 3) / 4;

  typedef enum logic [3:0] {
    IDLE, SEL, WR_ADDR, WR_RW, WR_NB, WR_RO, WR_ENA,
    RD_ACK, RD_USEDW, RD_FIFO, DONE
  } state_t;

  state_t      state, state_n;
  logic        gap, gap_n;
  logic [2:0]  k, k_n;
  logic        widx, widx_n;

  logic        enable;
  logic [3:0]  mask;
  logic [8:0]  status, status_set, status_clr;
  logic [31:0] sweep_count;
  logic [31:0] tick_cnt;
  logic        tick;
  logic        ack_nz;
  logic        fail;
  logic        bad;
  logic [31:0] samples [4][2];

  logic        xfer_state, rd_state, req, done_xfer;
  logic        unused_ok;

  assign unused_ok = ^{s_read, s_writedata[31:9]};

  assign tick = (tick_cnt == 32'(TICK_PERIOD - 1));

  assign xfer_state = state inside {WR_ADDR, WR_RW, WR_NB, WR_RO,
                                    WR_ENA, RD_ACK, RD_USEDW, RD_FIFO};
  assign rd_state   = state inside {RD_ACK, RD_USEDW, RD_FIFO};
  // gap forces one idle cycle between bus transfers
  assign req        = xfer_state && !gap;
  assign m_read     = req && rd_state;
  assign m_write    = req && !rd_state;
  assign done_xfer  = req && !m_waitrequest;
  assign bad        = ack_nz || (m_readdata < 32'(WORDS));

  always_comb begin
    m_address   = '0;
    m_writedata = '0;
    unique case (state)
      WR_ADDR: begin
        m_address   = 4'd0;
        m_writedata = {25'b0, BASE_ADDR + {4'b0, k}};
      end
      WR_RW:    begin m_address = 4'd2; m_writedata = 32'd1; end
      WR_NB:    begin m_address = 4'd4; m_writedata = 32'(READ_BYTES); end
      WR_RO:    begin m_address = 4'd6; m_writedata = 32'd1; end
      WR_ENA:   begin m_address = 4'd3; m_writedata = 32'd1; end
      RD_ACK:   m_address = 4'd5;
      RD_USEDW: m_address = 4'd6;
      RD_FIFO:  m_address = 4'd1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      gap   <= 1'b0;
      k     <= '0;
      widx  <= 1'b0;
    end else begin
      state <= state_n;
      gap   <= gap_n;
      k     <= k_n;
      widx  <= widx_n;
    end
  end

  always_comb begin
    state_n = state;
    gap_n   = gap;
    k_n     = k;
    widx_n  = widx;
    if (gap) begin
      gap_n = 1'b0;
      unique case (state)
        WR_ADDR: state_n = WR_RW;
        WR_RW:   state_n = WR_NB;
        WR_NB:   state_n = WR_RO;
        WR_RO:   state_n = WR_ENA;
        WR_ENA:  state_n = RD_ACK;
        RD_ACK:  state_n = RD_USEDW;
        RD_USEDW: begin
          if (fail) begin
            state_n = SEL;
            k_n     = k + 3'd1;
          end else begin
            state_n = RD_FIFO;
            widx_n  = 1'b0;
          end
        end
        RD_FIFO: begin
          if (widx == 1'(WORDS - 1)) begin
            state_n = SEL;
            k_n     = k + 3'd1;
          end else begin
            widx_n = widx + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (tick && enable) begin
            state_n = SEL;
            k_n     = '0;
          end
        end
        SEL: begin
          if (!enable)                       state_n = IDLE;
          else if (k >= 3'(NUM_SENSORS))     state_n = DONE;
          else if (mask[k[1:0]])             state_n = WR_ADDR;
          else                               k_n = k + 3'd1;
        end
        DONE:    state_n = IDLE;
        default: if (done_xfer) gap_n = 1'b1;
      endcase
    end
  end

  always_comb begin
    status_set = '0;
    status_clr = '0;
    if (done_xfer && state == RD_USEDW && bad)
      status_set[k[1:0]] = 1'b1;
    if (tick && state != IDLE)
      status_set[8] = 1'b1;
    if (s_write && s_address == 5'd1)
      status_clr = s_writedata[8:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable      <= 1'b0;
      mask        <= 4'hF;
      status      <= '0;
      sweep_count <= '0;
      tick_cnt    <= '0;
      ack_nz      <= 1'b0;
      fail        <= 1'b0;
      samples     <= '{default: '0};
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
      status   <= (status & ~status_clr) | status_set;
      if (s_write && s_address == 5'd0) enable <= s_writedata[0];
      if (s_write && s_address == 5'd3) mask <= s_writedata[3:0];
      if (state == DONE) sweep_count <= sweep_count + 32'd1;
      if (done_xfer && state == RD_ACK) ack_nz <= |m_readdata;
      if (done_xfer && state == RD_USEDW) fail <= bad;
      if (done_xfer && state == RD_FIFO)
        samples[k[1:0]][widx] <= m_readdata;
    end
  end

`ifdef I2C_SENSOR_POLLER_TIMESTAMP_EN
  logic [31:0] cyc;
  logic [31:0] ts_hold;
  logic [31:0] ts [4];

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc     <= '0;
      ts_hold <= '0;
      ts      <= '{default: '0};
    end else begin
      cyc <= cyc + 32'd1;
      if (done_xfer && state == RD_ACK) ts_hold <= cyc;
      if (done_xfer && state == RD_USEDW && !bad)
        ts[k[1:0]] <= ts_hold;
    end
  end
`endif

  always_comb begin
    s_readdata = 32'hDEAD_BEEF;
    if (s_address == 5'd0) begin
      s_readdata = {31'b0, enable};
    end else if (s_address == 5'd1) begin
      s_readdata = {23'b0, status};
    end else if (s_address == 5'd2) begin
      s_readdata = sweep_count;
    end else if (s_address == 5'd3) begin
      s_readdata = {28'b0, mask};
    end else if (s_address[4:3] == 2'b01) begin
      if ({1'b0, s_address[2:1]} < 3'(NUM_SENSORS) &&
          {1'b0, s_address[0]} < 2'(WORDS))
        s_readdata = samples[s_address[2:1]][s_address[0]];
`ifdef I2C_SENSOR_POLLER_TIMESTAMP_EN
    end else if (s_address[4:2] == 3'b100) begin
      if ({1'b0, s_address[1:0]} < 3'(NUM_SENSORS))
        s_readdata = ts[s_address[1:0]];
`endif
    end
  end

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb_i2c_sensor_poller: bridge model plus scoreboard for bus transfers and slave reads.
// Compile with I2C_SENSOR_POLLER_TIMESTAMP_EN to exercise the timestamp registers.
module tb_i2c_sensor_poller;

  localparam int TICK = 400;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  s_address;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_read;
  logic [31:0] s_readdata;
  logic [3:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  always #5 clock = ~clock;

  i2c_sensor_poller #(
    .CLOCK_SPEED_HZ(50_000_000),
    .POLL_RATE_HZ(125_000),
    .NUM_SENSORS(4),
    .BASE_ADDR(7'h35),
    .READ_BYTES(7)
  ) dut (
    .clock(clock), .reset(reset),
    .s_address(s_address), .s_write(s_write),
    .s_writedata(s_writedata), .s_read(s_read),
    .s_readdata(s_readdata),
    .m_address(m_address), .m_write(m_write),
    .m_writedata(m_writedata), .m_read(m_read),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  int n_chk = 0;
  int n_fail = 0;

  // bridge model
  logic [31:0] fdata [4][2];
  logic [31:0] ack_err [4];
  logic        stall_ack = 1'b0;
  logic [1:0]  cur_k = 2'd0;
  logic        fidx = 1'b0;
  logic        req_prev = 1'b0;
  int          cnt = 0;
  logic        req, first;

  assign req   = m_read | m_write;
  assign first = req && !req_prev;
  assign m_waitrequest = req && (first ?
    (stall_ack && m_read && m_address == 4'd5) : (cnt > 0));

  always @(posedge clock) begin
    req_prev <= req;
    if (first)
      cnt <= (stall_ack && m_read && m_address == 4'd5) ? 499 : 0;
    else if (cnt > 0)
      cnt <= cnt - 1;
    if (req && !m_waitrequest) begin
      if (m_write && m_address == 4'd0) begin
        cur_k <= 2'(m_writedata[6:0] - 7'h35);
        fidx  <= 1'b0;
      end
      if (m_read && m_address == 4'd1) fidx <= fidx + 1'b1;
    end
  end

  always_comb begin
    m_readdata = '0;
    if (m_address == 4'd5)      m_readdata = ack_err[cur_k];
    else if (m_address == 4'd6) m_readdata = 32'd2;
    else if (m_address == 4'd1) m_readdata = fdata[cur_k][fidx];
  end

  // scoreboard queues
  logic [36:0] bus_q [$];
  logic [31:0] reg_q [$];
  string       name_q [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic exp_w(logic [3:0] a, logic [31:0] d);
    bus_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_r(logic [3:0] a);
    bus_q.push_back({1'b0, a, 32'h0});
  endtask

  task automatic exp_sensor(int k, bit fifo);
    exp_w(4'd0, 32'(32'h35 + k));
    exp_w(4'd2, 32'd1);
    exp_w(4'd4, 32'd7);
    exp_w(4'd6, 32'd1);
    exp_w(4'd3, 32'd1);
    exp_r(4'd5);
    exp_r(4'd6);
    if (fifo) begin
      exp_r(4'd1);
      exp_r(4'd1);
    end
  endtask

  // monitor
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [37:0] snap = '0;

  always @(negedge clock) begin
    logic [36:0] e, act;
    logic [31:0] ev;
    string       nm;
    if (!reset) begin
      if (prev_stall) begin
        n_chk++;
        if ({m_read, m_write, m_address, m_writedata} !== snap) begin
          n_fail++;
          $display("FAIL stall_stable: got %h required %h",
                   {m_read, m_write, m_address, m_writedata}, snap);
        end
      end
      if (prev_done) begin
        n_chk++;
        if (req) begin
          n_fail++;
          $display("FAIL req_gap: got req=1 required req=0");
        end
      end
      if (req && !m_waitrequest) begin
        n_chk++;
        act = {m_write, m_address, m_write ? m_writedata : 32'h0};
        if (bus_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_xfer: got %h required none", act);
        end else begin
          e = bus_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL bus_xfer: got %h required %h", act, e);
          end
        end
      end
      prev_stall = req && m_waitrequest;
      prev_done  = req && !m_waitrequest;
      snap       = {m_read, m_write, m_address, m_writedata};
    end
    if (s_read && reg_q.size() != 0) begin
      ev = reg_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, s_readdata, ev);
    end
  end

  task automatic wr(logic [4:0] a, logic [31:0] d);
    @(posedge clock); #1;
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(posedge clock); #1;
    s_write = 1'b0;
  endtask

  task automatic rd_check(string name, logic [4:0] a, logic [31:0] exp);
    @(posedge clock); #1;
    reg_q.push_back(exp);
    name_q.push_back(name);
    s_address = a; s_read = 1'b1;
    @(posedge clock); #1;
    s_read = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 3000; i++) begin
      if (bus_q.size() == 0) break;
      @(posedge clock);
    end
    n_chk++;
    if (bus_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending required 0", name, bus_q.size());
      bus_q.delete();
    end
    repeat (12) @(posedge clock);
    wr(5'd0, 32'd0);
  endtask

`ifdef I2C_SENSOR_POLLER_TIMESTAMP_EN
  task automatic rd_val(logic [4:0] a, output logic [31:0] v);
    @(posedge clock); #1;
    s_address = a;
    #1 v = s_readdata;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < 4; i++) begin
      ack_err[i]  = '0;
      fdata[i][0] = '0;
      fdata[i][1] = '0;
    end
    reset = 1'b1;
    s_address = '0; s_write = 1'b0; s_writedata = '0; s_read = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_m_read", {31'b0, m_read}, 32'd0);
    chk("rst_m_write", {31'b0, m_write}, 32'd0);
    chk("rst_m_address", {28'b0, m_address}, 32'd0);
    chk("rst_m_writedata", m_writedata, 32'd0);
    rd_check("rst_ctrl", 5'd0, 32'd0);
    rd_check("rst_status", 5'd1, 32'd0);
    rd_check("rst_count", 5'd2, 32'd0);
    rd_check("rst_mask", 5'd3, 32'hF);
    rd_check("rst_samp0", 5'd8, 32'd0);
    rd_check("hole_4", 5'd4, 32'hDEAD_BEEF);
    rd_check("hole_31", 5'd31, 32'hDEAD_BEEF);
`ifdef I2C_SENSOR_POLLER_TIMESTAMP_EN
    rd_check("rst_ts0", 5'd16, 32'd0);
`else
    rd_check("ts0_absent", 5'd16, 32'hDEAD_BEEF);
`endif

    // single sensor sweep
    fdata[0][0] = 32'h1122_3344; fdata[0][1] = 32'h5566_7700;
    wr(5'd3, 32'h1);
    exp_sensor(0, 1);
    wr(5'd0, 32'd1);
    drain("sweep1");
    rd_check("s1_samp0", 5'd8, 32'h1122_3344);
    rd_check("s1_samp1", 5'd9, 32'h5566_7700);
    rd_check("s1_count", 5'd2, 32'd1);
    rd_check("s1_status", 5'd1, 32'd0);

    // four sensors, sensor 2 NACKs
    fdata[0][0] = 32'hA0A1_A2A3; fdata[0][1] = 32'hA4A5_A6A7;
    fdata[1][0] = 32'hB0B1_B2B3; fdata[1][1] = 32'hB4B5_B6B7;
    fdata[2][0] = 32'hC0C1_C2C3; fdata[2][1] = 32'hC4C5_C6C7;
    fdata[3][0] = 32'hD0D1_D2D3; fdata[3][1] = 32'hD4D5_D6D7;
    ack_err[2] = 32'd1;
    wr(5'd3, 32'hF);
    exp_sensor(0, 1);
    exp_sensor(1, 1);
    exp_sensor(2, 0);
    exp_sensor(3, 1);
    wr(5'd0, 32'd1);
    drain("sweep4");
    ack_err[2] = 32'd0;
    rd_check("nack_status", 5'd1, 32'h004);
    rd_check("nack_s0w0", 5'd8, 32'hA0A1_A2A3);
    rd_check("nack_s0w1", 5'd9, 32'hA4A5_A6A7);
    rd_check("nack_s1w0", 5'd10, 32'hB0B1_B2B3);
    rd_check("nack_s2w0", 5'd12, 32'd0);
    rd_check("nack_s2w1", 5'd13, 32'd0);
    rd_check("nack_s3w1", 5'd15, 32'hD4D5_D6D7);
    rd_check("nack_count", 5'd2, 32'd2);
    wr(5'd1, 32'h4);
    rd_check("nack_clear", 5'd1, 32'd0);

    // 500-cycle stall on RD_ACK outlasts the tick -> overrun
    fdata[0][0] = 32'hC001_0000; fdata[0][1] = 32'hC001_0001;
    stall_ack = 1'b1;
    wr(5'd3, 32'h1);
    exp_sensor(0, 1);
    wr(5'd0, 32'd1);
    drain("stall");
    stall_ack = 1'b0;
    rd_check("ovr_status", 5'd1, 32'h100);
    rd_check("ovr_count", 5'd2, 32'd3);
    rd_check("ovr_samp0", 5'd8, 32'hC001_0000);
    wr(5'd1, 32'h100);
    rd_check("ovr_clear", 5'd1, 32'd0);

    // disable during sensor 1 WR_RW
    fdata[0][0] = 32'hE0E0_0000; fdata[1][0] = 32'hF1F1_0000;
    wr(5'd3, 32'hF);
    exp_sensor(0, 1);
    exp_sensor(1, 1);
    wr(5'd0, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (m_write && m_address == 4'd2 && cur_k == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_seen_wr_rw", {31'b0, found}, 32'd1);
    wr(5'd0, 32'd0);
    drain("abort");
    repeat (TICK + 50) @(posedge clock);
    chk("abort_no_more", 32'(bus_q.size()), 32'd0);
    rd_check("abort_idle_status", 5'd1, 32'd0);
    rd_check("abort_s0w0", 5'd8, 32'hE0E0_0000);
    rd_check("abort_s1w0", 5'd10, 32'hF1F1_0000);
    rd_check("abort_s3w0", 5'd14, 32'hD0D1_D2D3);

`ifdef I2C_SENSOR_POLLER_TIMESTAMP_EN
    begin
      logic [31:0] t1, t2;
      wr(5'd3, 32'h1);
      exp_sensor(0, 1);
      exp_sensor(0, 1);
      wr(5'd0, 32'd1);
      for (int i = 0; i < 3000; i++) begin
        if (bus_q.size() <= 9) break;
        @(posedge clock);
      end
      repeat (20) @(posedge clock);
      rd_val(5'd16, t1);
      drain("ts");
      rd_val(5'd16, t2);
      chk("ts_delta", t2 - t1, 32'(TICK));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
